i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) that sits on the same two-wire bus as the team's I2C initiator driver.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a fixed 7-bit address. For writes, receives bytes and ACKs each one. For reads, shifts out bytes supplied by the user logic and samples the initiator's ACK/NACK.
- SDA is driven open-drain through an output-enable only.

Parameters:
SLAVE_ADDR, 7'h27, 7-bit bus address this block responds to
SYNC_STAGES, 2, flop stages on scl and sda_in before edge detection (min 2)

Ports:
clk  input  1  system clock; must be >= 8x SCL frequency
rst  input  1  synchronous, active-low reset
scl  input  1  bus clock, asynchronous to clk
sda_in  input  1  bus data as read from the pad, asynchronous
sda_oe  output  1  1 = pull SDA low; 0 = release (pull-up gives 1)
rx_data  output  8  last byte received in a write transfer
rx_valid  output  1  one-clk pulse when rx_data updates
tx_data  input  8  byte to return in a read transfer
tx_load  output  1  one-clk pulse when tx_data has been captured into the shift register
rd_nack  output  1  one-clk pulse when the initiator NACKs a read byte
busy  output  1  high from address match until STOP or repeated START
rw  output  1  R/W bit of the current transfer (1 = read)

Behaviour:
- Reset: when rst=0 at a clk edge, all outputs go to 0, state goes to IDLE, shift registers and bit counter clear. This applies mid-byte too; the bus is released the cycle after reset.
- Sync and edge detect: scl/sda pass through SYNC_STAGES flops, plus one history flop each.
  - scl_rise / scl_fall are single-cycle strobes.
  - START = synced sda falls while synced scl=1. STOP = synced sda rises while synced scl=1.
  - Latency from pin edge to strobe is SYNC_STAGES+1 clks.
- Data bits are sampled on scl_rise. sda_oe changes only on scl_fall, except on STOP or reset.
- Bit order is MSB first. The first 8 bits after START are addr[6:0] followed by R/W (0 = write).
- States:
  - IDLE: wait for START, then go to ADDR with the bit counter at 0.
  - ADDR: shift 8 bits. On the scl_fall after bit 8:
    - if addr == SLAVE_ADDR: set sda_oe=1, busy=1, latch rw, go to ADDR_ACK;
    - otherwise go to WAIT_STOP with sda_oe=0.
  - ADDR_ACK: on the next scl_fall:
    - rw=0: release SDA, go to WR_DATA.
    - rw=1: capture tx_data, pulse tx_load, drive sda_oe = ~tx_bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On the 8th rise, update rx_data and pulse rx_valid the same clk. On the following scl_fall, set sda_oe=1 and go to WR_ACK.
  - WR_ACK: on scl_fall, release SDA and go to WR_DATA. Multi-byte writes are unlimited.
  - RD_DATA: on each scl_fall, present the next bit with sda_oe = ~bit. After the 8th bit's scl_fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - 0 = ACK: on the next scl_fall, capture tx_data, pulse tx_load, drive bit7, return to RD_DATA.
    - 1 = NACK: pulse rd_nack, go to WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bits until STOP or START.
- STOP in any state: go to IDLE, sda_oe=0, busy=0, same clk as the strobe.
- START in any state (repeated start): go to ADDR, busy=0, sda_oe=0, bit counter cleared.
- If START/STOP and scl_rise coincide, START/STOP wins.
- A partial byte interrupted by STOP/START never produces rx_valid.
- rx_data holds its value until the next complete byte.
- The bit counter is 3 bits and wraps 7->0 at each byte boundary.
- The block never stretches SCL.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP);
  - constants I2C_ADDR_W=7, I2C_BYTE_W=8, RW_WRITE=0, RW_READ=1.
- One natural sub-module, i2c_line_sync: SYNC_STAGES synchronizer plus edge detector for both lines. It outputs scl_rise, scl_fall, start_det, stop_det and the synced sda.

Test Plan:
- Write: START, addr 0x27, W, data 0x18, STOP -> ACK (SDA low) on the 9th clock of both bytes; rx_data=0x18 with one rx_valid pulse; busy falls at STOP.
- Read: tx_data=0xA5, START, 0x27, R -> tx_load pulse, bus bits 1,0,1,0,0,1,0,1. Initiator NACK -> rd_nack pulse, SDA released, IDLE after STOP.
- Mismatch: START, addr 0x28, W, 0x55 -> sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Multi-byte with repeated start: write 0x11, 0x22, then repeated START to read with ACK then NACK (tx_data 0x3C then 0xC3) -> two rx_valid pulses (0x11, 0x22), two tx_load pulses, correct bus bytes.
- Abort mid-byte: STOP after 4 data bits -> no rx_valid, IDLE. A separate run asserts rst=0 while sda_oe=1 -> sda_oe=0 the next clk, all outputs 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// I2C responder shared types: FSM states and bus field widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;
    localparam int   I2C_ADDR_W = 7;
    localparam int   I2C_BYTE_W = 8;
    localparam logic RW_WRITE   = 1'b0;
    localparam logic RW_READ    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises scl/sda and produces single-cycle edge, START and STOP strobes.
// Latency: pin edge to strobe is SYNC_STAGES+1 clk; sda_sync is aligned with the strobes.
// Backpressure: none, free-running.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);
    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_ff[SYNC_STAGES-1];
    assign sda_now = sda_ff[SYNC_STAGES-1];

    // Chains reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_ff    <= '1;
            sda_ff    <= '1;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_sync  <= 1'b1;
        end else begin
            scl_ff    <= {scl_ff[SYNC_STAGES-2:0], scl};
            sda_ff    <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_hist  <= scl_now;
            sda_hist  <= sda_now;
            scl_rise  <= scl_now & ~scl_hist;
            scl_fall  <= ~scl_now & scl_hist;
            start_det <= sda_hist & ~sda_now & scl_now & scl_hist;
            stop_det  <= ~sda_hist & sda_now & scl_now & scl_hist;
            sda_sync  <= sda_now;
        end
    end
endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: address match, ACKed multi-byte writes, reads fed from tx_data.
// Latency: reacts SYNC_STAGES+2 clk after a bus edge; sda_oe moves only after scl falls.
// Backpressure: none; never stretches SCL, tx_data must be valid when tx_load fires.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h27,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [I2C_BYTE_W-1:0] tx_data,
    output logic                  tx_load,
    output logic                  rd_nack,
    output logic                  busy,
    output logic                  rw
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_sync;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda_sync)
    );

    state_t                state;
    logic [2:0]            bit_cnt;
    logic                  byte_done;   // 8 bits sampled (or ACK seen), act on next scl_fall
    logic [I2C_BYTE_W-1:0] shreg;
    logic [I2C_BYTE_W-2:0] tx_sh;       // remaining read bits after the one on the bus

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            shreg     <= '0;
            tx_sh     <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            rd_nack   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            rd_nack  <= 1'b0;
            if (stop_det || start_det) begin
                state     <= stop_det ? IDLE : ADDR;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                                state  <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw == RW_WRITE) begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end else begin
                                tx_sh   <= tx_data[6:0];
                                tx_load <= 1'b1;
                                sda_oe  <= ~tx_data[7];
                                state   <= RD_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= {shreg[6:0], sda_sync};
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b1;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                sda_oe <= ~tx_sh[6];
                                tx_sh  <= {tx_sh[5:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync) begin
                                rd_nack <= 1'b1;
                                sda_oe  <= 1'b0;
                                state   <= WAIT_STOP;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            tx_sh     <= tx_data[6:0];
                            tx_load   <= 1'b1;
                            sda_oe    <= ~tx_data[7];
                            state     <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus initiator drives randomized transactions
// while a scoreboard checks rx_valid / tx_load / rd_nack pulses against a reference model.
module tb_i2c_slave_responder;
    localparam logic [6:0] MY_ADDR = 7'h27;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       drv = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_load, rd_nack, busy, rw;
    logic [7:0] rx_data;
    logic       sda_line;

    assign sda_line = drv & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(MY_ADDR), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rd_nack  (rd_nack),
        .busy     (busy),
        .rw       (rw)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    int         exp_nack = 0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] buf_d [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
            if (tx_load) begin
                if (exp_tx.size() == 0) check("tx_load_unexpected", tx_load, 0);
                else check("tx_load_byte", tx_data, exp_tx.pop_front());
            end
            if (rd_nack) begin
                check("rd_nack_expected", exp_nack > 0, 1);
                if (exp_nack > 0) exp_nack--;
            end
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic bus_start();
        drv = 1'b1; #60; scl = 1'b1; #60; drv = 1'b0; #60; scl = 1'b0; #60;
    endtask

    task automatic bus_stop();
        drv = 1'b0; #60; scl = 1'b1; #60; drv = 1'b1; #60;
    endtask

    task automatic bus_bit(input logic b, output logic s);
        drv = b; #60; scl = 1'b1; #50; s = sda_line; #50; scl = 1'b0; #60;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack, input logic [7:0] nxt);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        tx_data = nxt;
        bus_bit(nack, s);
    endtask

    // Reference model: only a matching address gets ACKs and produces pulses.
    task automatic wr_txn(input logic [6:0] a, input int n);
        logic ack;
        logic match;
        match = (a == MY_ADDR);
        bus_start();
        send_byte({a, 1'b0}, ack);
        check("addr_ack_w", ack, !match);
        check("busy_after_addr_w", busy, match);
        for (int i = 0; i < n; i++) begin
            if (match) exp_rx.push_back(buf_d[i]);
            send_byte(buf_d[i], ack);
            check("data_ack", ack, !match);
        end
    endtask

    task automatic rd_txn(input logic [6:0] a, input int n);
        logic       ack;
        logic       match;
        logic       last;
        logic [7:0] got;
        logic [7:0] nxt;
        match = (a == MY_ADDR);
        tx_data = buf_d[0];
        if (match) exp_tx.push_back(buf_d[0]);
        bus_start();
        send_byte({a, 1'b1}, ack);
        check("addr_ack_r", ack, !match);
        check("rw_latched", match ? rw : 1'b1, 1);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            nxt  = last ? 8'($urandom) : buf_d[i+1];
            if (match && !last) exp_tx.push_back(buf_d[i+1]);
            if (match && last) exp_nack++;
            recv_byte(got, last, nxt);
            check("rd_byte", got, match ? buf_d[i] : 8'hFF);
        end
    endtask

    task automatic finish_txn(input logic match);
        bus_stop();
        #100;
        check("busy_after_stop", busy, 0);
        check("sda_released_after_stop", sda_oe, 0);
        if (!match) begin
            check("mismatch_oe_quiet", oe_seen, 0);
            check("mismatch_busy_quiet", busy_seen, 0);
        end
    endtask

    initial begin
        logic       s;
        logic [6:0] a;
        int         kind, n;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {sda_oe, busy, rw, rx_valid, tx_load, rd_nack, rx_data}, 0);
        rst = 1'b1;
        #200;

        // Directed write of 0x18
        buf_d[0] = 8'h18;
        wr_txn(MY_ADDR, 1);
        finish_txn(1'b1);

        // Directed read of 0xA5 with NACK
        buf_d[0] = 8'hA5;
        rd_txn(MY_ADDR, 1);
        finish_txn(1'b1);

        // Address mismatch
        oe_seen = 1'b0; busy_seen = 1'b0;
        buf_d[0] = 8'h55;
        wr_txn(7'h28, 1);
        finish_txn(1'b0);

        // Two-byte write, repeated START, two-byte read
        buf_d[0] = 8'h11; buf_d[1] = 8'h22;
        wr_txn(MY_ADDR, 2);
        buf_d[0] = 8'h3C; buf_d[1] = 8'hC3;
        rd_txn(MY_ADDR, 2);
        finish_txn(1'b1);

        // STOP after four data bits: no rx_valid may appear
        bus_start();
        send_byte({MY_ADDR, 1'b0}, s);
        check("abort_addr_ack", s, 0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), s);
        finish_txn(1'b1);

        // Randomized transactions
        for (int k = 0; k < 10; k++) begin
            kind = $urandom_range(0, 1);
            n    = $urandom_range(1, 3);
            a    = MY_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                do a = 7'($urandom); while (a == MY_ADDR);
            end
            for (int i = 0; i < 4; i++) buf_d[i] = 8'($urandom);
            oe_seen = 1'b0; busy_seen = 1'b0;
            if (kind == 0) wr_txn(a, n);
            else rd_txn(a, n);
            finish_txn(a == MY_ADDR);
        end

        // Reset while the address ACK is being driven
        bus_start();
        for (int i = 6; i >= 0; i--) bus_bit(MY_ADDR[i], s);
        bus_bit(1'b0, s);
        check("ack_driven_before_reset", sda_oe, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_outputs", {sda_oe, busy, rw, rx_valid, tx_load, rd_nack, rx_data}, 0);
        #40;
        rst = 1'b1;
        bus_stop();
        #200;

        check("rx_queue_drained", exp_rx.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("nack_expect_drained", exp_nack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
